// File: rtl/counter_pkg.sv
// Shared constants and helpers for counter_mod.
// Direction/mode encodings plus the load-value clamp used at elaboration-independent widths.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  localparam bit   MODE_WRAP = 1'b0;
  localparam bit   MODE_SAT  = 1'b1;

  // Operates on 32-bit values so one function serves every WIDTH; callers truncate.
  function automatic logic [31:0] clamp_load(input logic [31:0] d, input logic [31:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/counter_mod.sv
// Up/down modulo-(MAX+1) counter with load, enable, wrap-or-saturate and tc/ovf flags.
// Latency: O and ovf one clk after the qualifying edge, tc combinational; no backpressure.
module counter_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX      = 2**WIDTH-1,
  parameter bit          SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             R,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] O,
  output logic             tc,
  output logic             ovf
);

  localparam longint unsigned LIMIT = (64'd1 << WIDTH) - 64'd1;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "counter_mod: WIDTH must be 1..32");
  end
  if (MAX < 1 || longint'(MAX) > LIMIT) begin : g_bad_max
    $fatal(1, "counter_mod: MAX must be 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] load_val;
  logic             at_max, at_zero;

  assign load_val = WIDTH'(clamp_load(32'(D), 32'(MAX)));

  // >= rather than == so a wrap decision never depends on natural rollover.
  assign at_max  = (cnt_q >= MAXV);
  assign at_zero = (cnt_q == '0);

  assign tc = en & ~load & ((up == DIR_UP) ? at_max : at_zero);

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (up == DIR_UP) begin
        if (at_max) begin
          ovf_d = 1'b1;
          cnt_d = (SATURATE == MODE_SAT) ? MAXV : '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          ovf_d = 1'b1;
          cnt_d = (SATURATE == MODE_SAT) ? '0 : MAXV;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign O   = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_counter_mod.sv
// Scoreboarded bench for counter_mod: three instances (4b/9 wrap, 4b/9 saturate, 8b/255 wrap).
// Stimulus queues hand-computed {O, tc, ovf} per cycle; a negedge monitor pops and compares.
module tb_counter_mod;

  typedef struct {
    int    id;
    int    o;
    bit    tc;
    bit    ovf;
    string nm;
  } exp_t;

  logic       clk;
  logic       r   [3];
  logic       en  [3];
  logic       up  [3];
  logic       ld  [3];
  logic [7:0] d   [3];

  logic [3:0] o0, o1;
  logic [7:0] o2;
  logic       tc0, tc1, tc2;
  logic       ovf0, ovf1, ovf2;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  counter_mod #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .R(r[0]), .en(en[0]), .up(up[0]), .load(ld[0]), .D(d[0][3:0]),
    .O(o0), .tc(tc0), .ovf(ovf0)
  );

  counter_mod #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .R(r[1]), .en(en[1]), .up(up[1]), .load(ld[1]), .D(d[1][3:0]),
    .O(o1), .tc(tc1), .ovf(ovf1)
  );

  counter_mod #(.WIDTH(8), .MAX(255), .SATURATE(1'b0)) u_full (
    .clk(clk), .R(r[2]), .en(en[2]), .up(up[2]), .load(ld[2]), .D(d[2]),
    .O(o2), .tc(tc2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Monitor: each queued entry describes the outputs visible at the next falling edge.
  always @(negedge clk) begin
    exp_t e;
    int   ao;
    int   atc;
    int   aovf;
    if (q.size() > 0) begin
      e = q.pop_front();
      case (e.id)
        0:       begin ao = int'(o0); atc = int'(tc0); aovf = int'(ovf0); end
        1:       begin ao = int'(o1); atc = int'(tc1); aovf = int'(ovf1); end
        default: begin ao = int'(o2); atc = int'(tc2); aovf = int'(ovf2); end
      endcase
      cmp({e.nm, ".O"},   ao,   e.o);
      cmp({e.nm, ".tc"},  atc,  int'(e.tc));
      cmp({e.nm, ".ovf"}, aovf, int'(e.ovf));
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue what the
  // outputs must read before the next rising edge.
  task automatic step(input int id, input bit r_, input bit en_, input bit up_,
                      input bit ld_, input int d_, input int eo, input bit etc,
                      input bit eovf, input string nm);
    @(posedge clk);
    #1;
    r[id]  = r_;
    en[id] = en_;
    up[id] = up_;
    ld[id] = ld_;
    d[id]  = 8'(d_);
    q.push_back('{id: id, o: eo, tc: etc, ovf: eovf, nm: nm});
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      r[i] = 1'b0; en[i] = 1'b1; up[i] = 1'b1; ld[i] = 1'b0; d[i] = 8'd0;
    end

    // Reset held, then released after t=30 with en=1 up=1.
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, "rst_hold0");
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, "rst_hold1");
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, "rst_hold2");
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, "rst_release");
    for (int v = 1; v <= 9; v++)
      step(0, 1, 1, 1, 0, 0, v, (v == 9), 0, $sformatf("up_cnt%0d", v));
    step(0, 1, 1, 1, 0, 0, 0, 0, 1, "up_wrap");
    step(0, 1, 1, 1, 0, 0, 1, 0, 0, "up_after_wrap");

    // Load and clamp; load masks tc even at the limit.
    step(0, 1, 1, 1, 1, 5,  2, 0, 0, "load5");
    step(0, 1, 1, 1, 1, 14, 5, 0, 0, "load14");
    step(0, 1, 1, 1, 1, 3,  9, 0, 0, "load_at_max");
    step(0, 1, 0, 1, 0, 0,  3, 0, 0, "hold_after_load");

    // Down-count wrap, immediate direction change, wrap back up.
    step(0, 1, 1, 0, 0, 0, 3, 0, 0, "dn3");
    step(0, 1, 1, 0, 0, 0, 2, 0, 0, "dn2");
    step(0, 1, 1, 0, 0, 0, 1, 0, 0, "dn1");
    step(0, 1, 1, 0, 0, 0, 0, 1, 0, "dn0_tc");
    step(0, 1, 1, 1, 0, 0, 9, 1, 1, "dn_wrap_then_up");
    step(0, 1, 0, 1, 0, 0, 0, 0, 1, "up_wrap_again");
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, "ovf_drop");

    // Asynchronous reset between edges from O=7.
    step(0, 1, 1, 1, 1, 7, 0, 0, 0, "load7");
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, "async_rst_mid");
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, "post_rst_hold0");
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, "post_rst_hold1");

    // Saturating instance: down from 2, then up into MAX, then reset while ovf high.
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, "sat_release");
    step(1, 1, 0, 1, 1, 2, 0, 0, 0, "sat_load2");
    step(1, 1, 1, 0, 0, 0, 2, 0, 0, "sat_dn2");
    step(1, 1, 1, 0, 0, 0, 1, 0, 0, "sat_dn1");
    step(1, 1, 1, 0, 0, 0, 0, 1, 0, "sat_dn0");
    step(1, 1, 1, 0, 0, 0, 0, 1, 1, "sat_hold0a");
    step(1, 1, 1, 0, 0, 0, 0, 1, 1, "sat_hold0b");
    step(1, 1, 0, 0, 0, 0, 0, 0, 1, "sat_en_off");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, "sat_ovf_drop");
    step(1, 1, 0, 1, 1, 8, 0, 0, 0, "sat_load8");
    step(1, 1, 1, 1, 0, 0, 8, 0, 0, "sat_up8");
    step(1, 1, 1, 1, 0, 0, 9, 1, 0, "sat_up9");
    step(1, 1, 1, 1, 0, 0, 9, 1, 1, "sat_hold9");
    step(1, 0, 1, 1, 0, 0, 0, 0, 0, "sat_async_rst");
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, "sat_post_rst");
    step(1, 1, 0, 1, 1, 15, 0, 0, 0, "sat_load15");
    step(1, 1, 0, 1, 0, 0, 9, 0, 0, "sat_clamped");

    // 8-bit full range: 256 edges back to 0 with one ovf, then reverse at 100.
    step(2, 1, 0, 1, 0, 0, 0, 0, 0, "full_release");
    for (int v = 0; v <= 255; v++)
      step(2, 1, 1, 1, 0, 0, v, (v == 255), 0, $sformatf("full%0d", v));
    step(2, 1, 1, 1, 0, 0, 0, 0, 1, "full_wrap");
    for (int v = 1; v <= 99; v++)
      step(2, 1, 1, 1, 0, 0, v, 0, 0, $sformatf("full_b%0d", v));
    step(2, 1, 1, 0, 0, 0, 100, 0, 0, "full_turn");
    step(2, 1, 0, 0, 0, 0, 99, 0, 0, "full_after_turn");

    @(negedge clk);
    #1;
    cmp("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
